// File: rtl/icu_pkg.sv
// -----------------------------------------------------------------------------
// icu_pkg
// Shared definitions for the ICU issue queue: opcode encodings, functional-unit
// channel indices, controller state encoding and the opcode-to-unit decoder.
// -----------------------------------------------------------------------------
package icu_pkg;

    // Opcodes live in instruction bits [31:24].
    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_MOVE  = 8'h02;
    localparam logic [7:0] OP_ADD   = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h04;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    // Issue channel indices.
    localparam int         UNIT_IDX_W = 2;
    localparam logic [1:0] UNIT_MEM   = 2'd0;
    localparam logic [1:0] UNIT_VXM   = 2'd1;
    localparam logic [1:0] UNIT_SRF   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_NOP_WAIT,
        ST_HALTED
    } icu_state_t;

    // legal is set only for opcodes that are issued to a functional unit.
    typedef struct packed {
        logic                  legal;
        logic [UNIT_IDX_W-1:0] unit;
    } unit_sel_t;

    function automatic unit_sel_t opcode_to_unit(input logic [7:0] opcode);
        unit_sel_t sel;
        sel.legal = 1'b1;
        sel.unit  = UNIT_MEM;
        case (opcode)
            OP_READ, OP_WRITE: sel.unit  = UNIT_MEM;
            OP_ADD:            sel.unit  = UNIT_VXM;
            OP_MOVE:           sel.unit  = UNIT_SRF;
            default:           sel.legal = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/icu_instr_fifo.sv
// -----------------------------------------------------------------------------
// icu_instr_fifo
// Synchronous FIFO with a registered head word. The head register is loaded
// at the same edge an entry becomes the head, so rdata is a pure flop output
// and a new head is available the cycle right after a pop.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, wdata   write one word (ignored when full without a pop, or on flush)
//   pop           drop the head word (ignored when empty)
//   flush         empty the FIFO; wins over push and pop
//   rdata         current head word (valid while !empty)
//   count         number of stored words, 0..DEPTH
//   full, empty   occupancy flags
// -----------------------------------------------------------------------------
module icu_instr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    remain;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = head_q;

    // NOTE: every signal written here gets a default before any branch, so no latch is inferred.
    always_comb begin
        do_pop   = pop && !empty && !flush;
        do_push  = push && !flush && (!full || do_pop);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        remain   = count_q - CW'(do_pop);
        head_d   = head_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (remain == '0) begin
            // Nothing left behind the head: an incoming word becomes the head directly.
            if (do_push) begin
                head_d = wdata;
            end
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; count and pointers guard every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/icu_issue_queue.sv
// -----------------------------------------------------------------------------
// icu_issue_queue
// Fetches instructions into a small FIFO and issues them in order to the
// MEM/VXM/SRF channels over valid/ready, handling NOP-N stalls and HALT.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start                  begin fetching at address 0 (from IDLE or HALTED)
//   instr_req/_address     fetch request and address
//   instr_valid/instr_in   fetch response, exactly one cycle after the request
//   unit_valid/unit_ready  one-hot issue strobe and per-unit accept
//   issue_opcode/_payload  fields of the instruction at the FIFO head
//   busy, halted           status (RUN/NOP_WAIT, HALTED)
//   illegal_op             one-cycle pulse when an undefined opcode is dropped
// -----------------------------------------------------------------------------
module icu_issue_queue
    import icu_pkg::*;
#(
    parameter int INSTR_WIDTH          = 32,
    parameter int INSTR_MEM_ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH           = 4,
    parameter int NUM_UNITS            = 3,
    parameter int NOP_CNT_WIDTH        = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    output logic                            instr_req,
    output logic [INSTR_MEM_ADDR_WIDTH-1:0] instr_address,
    input  logic                            instr_valid,
    input  logic [INSTR_WIDTH-1:0]          instr_in,
    output logic [NUM_UNITS-1:0]            unit_valid,
    input  logic [NUM_UNITS-1:0]            unit_ready,
    output logic [7:0]                      issue_opcode,
    output logic [23:0]                     issue_payload,
    output logic                            busy,
    output logic                            halted,
    output logic                            illegal_op
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    icu_state_t                      state_q, state_d;
    logic [INSTR_MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NOP_CNT_WIDTH-1:0]        nop_cnt_q, nop_cnt_d;
    logic                            outstanding_q;

    logic                   fifo_push, fifo_pop, fifo_flush;
    logic                   fifo_full, fifo_empty;
    logic [CW-1:0]          fifo_count;
    logic [INSTR_WIDTH-1:0] fifo_head;

    logic [7:0]               head_op;
    logic [NOP_CNT_WIDTH-1:0] head_nop_n;
    logic [CW:0]              in_flight;
    logic                     fetch_en;
    unit_sel_t                sel;

    assign head_op       = fifo_head[INSTR_WIDTH-1 -: 8];
    assign head_nop_n    = fifo_head[NOP_CNT_WIDTH-1:0];
    assign issue_opcode  = head_op;
    assign issue_payload = fifo_head[23:0];
    assign instr_address = addr_q;
    assign busy          = (state_q == ST_RUN) || (state_q == ST_NOP_WAIT);
    assign halted        = (state_q == ST_HALTED);

    // Words in the FIFO plus the one possibly in flight must fit in the FIFO.
    assign in_flight = {1'b0, fifo_count} + (CW+1)'(outstanding_q);

    // Responses are only accepted while fetching; HALT's flush also discards one.
    assign fifo_push = instr_valid && busy;

    icu_instr_fifo #(
        .WIDTH (INSTR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .wdata (instr_in),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        nop_cnt_d  = nop_cnt_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        unit_valid = '0;
        illegal_op = 1'b0;
        fetch_en   = 1'b0;
        instr_req  = 1'b0;
        sel        = opcode_to_unit(head_op);

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_d    = ST_RUN;
                    addr_d     = '0;
                    fifo_flush = 1'b1;
                end
            end

            ST_RUN: begin
                fetch_en = 1'b1;
                if (!fifo_empty) begin
                    case (head_op)
                        OP_NOP: begin
                            fifo_pop = 1'b1;
                            if (head_nop_n != '0) begin
                                state_d   = ST_NOP_WAIT;
                                nop_cnt_d = head_nop_n;
                            end
                        end
                        OP_HALT: begin
                            // Stop fetching in the pop cycle so nothing new is requested.
                            fifo_pop   = 1'b1;
                            fifo_flush = 1'b1;
                            fetch_en   = 1'b0;
                            state_d    = ST_HALTED;
                        end
                        default: begin
                            if (sel.legal) begin
                                unit_valid = NUM_UNITS'(1) << sel.unit;
                                fifo_pop   = |(unit_valid & unit_ready);
                            end else begin
                                fifo_pop   = 1'b1;
                                illegal_op = 1'b1;
                            end
                        end
                    endcase
                end
            end

            ST_NOP_WAIT: begin
                fetch_en  = 1'b1;
                nop_cnt_d = nop_cnt_q - 1'b1;
                if (nop_cnt_q == NOP_CNT_WIDTH'(1)) begin
                    state_d = ST_RUN;
                end
            end
        endcase

        instr_req = fetch_en && !fifo_full && (in_flight < (CW+1)'(FIFO_DEPTH));
        if (instr_req) begin
            addr_d = addr_q + INSTR_MEM_ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            nop_cnt_q     <= '0;
            outstanding_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            nop_cnt_q     <= nop_cnt_d;
            outstanding_q <= instr_req;
        end
    end

endmodule

// File: tb/tb_icu_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_icu_issue_queue
// Directed programs with hand-computed issue streams. Expected issues are
// queued by the stimulus; a monitor pops and compares on every handshake.
// A second instance with a 3-bit address checks the fetch address wrap.
// -----------------------------------------------------------------------------
module tb_icu_issue_queue;

    typedef struct {
        logic [2:0]  uv;
        logic [7:0]  op;
        logic [23:0] pl;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        instr_req;
    logic [9:0]  instr_address;
    logic        instr_valid;
    logic [31:0] instr_in;
    logic [2:0]  unit_valid;
    logic [2:0]  unit_ready;
    logic [7:0]  issue_opcode;
    logic [23:0] issue_payload;
    logic        busy, halted, illegal_op;

    logic        w_start, w_req, w_valid, w_busy, w_halted, w_ill;
    logic [2:0]  w_addr, w_uv, w_ready;
    logic [31:0] w_in;
    logic [7:0]  w_op;
    logic [23:0] w_pl;

    logic [31:0] imem [1024];
    exp_t        sb[$];
    int          hs_cyc[$];
    logic [9:0]  req_log[$];
    logic [2:0]  w_exp[$];
    int          cyc = 0;
    int          ill_cnt = 0;
    int          n_vec = 0;
    int          n_err = 0;

    logic        pend = 1'b0;
    logic [31:0] pend_word = '0;
    logic        w_pend = 1'b0;
    logic [31:0] w_pend_word = '0;
    int          w_idx = 0;

    icu_issue_queue u_dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .instr_req     (instr_req),
        .instr_address (instr_address),
        .instr_valid   (instr_valid),
        .instr_in      (instr_in),
        .unit_valid    (unit_valid),
        .unit_ready    (unit_ready),
        .issue_opcode  (issue_opcode),
        .issue_payload (issue_payload),
        .busy          (busy),
        .halted        (halted),
        .illegal_op    (illegal_op)
    );

    icu_issue_queue #(.INSTR_MEM_ADDR_WIDTH(3)) u_wrap (
        .clk           (clk),
        .rst           (rst),
        .start         (w_start),
        .instr_req     (w_req),
        .instr_address (w_addr),
        .instr_valid   (w_valid),
        .instr_in      (w_in),
        .unit_valid    (w_uv),
        .unit_ready    (w_ready),
        .issue_opcode  (w_op),
        .issue_payload (w_pl),
        .busy          (w_busy),
        .halted        (w_halted),
        .illegal_op    (w_ill)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Instruction memories: respond one cycle after each request.
    always @(negedge clk) begin
        instr_valid = pend;
        instr_in    = pend_word;
        pend        = instr_req;
        pend_word   = imem[instr_address];
        if (instr_req) req_log.push_back(instr_address);

        w_valid     = w_pend;
        w_in        = w_pend_word;
        w_pend      = w_req;
        w_pend_word = (w_idx == 9) ? 32'hFF00_0000 : 32'h0000_0000;
        if (w_req) w_idx++;
    end

    // Monitor: sampled mid-cycle, after the inputs for this cycle have settled.
    always @(negedge clk) begin
        #2;
        if (!rst && (unit_valid & unit_ready) != 3'b000) begin
            hs_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("extra_issue", 32'(unit_valid), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("issue_unit", 32'(unit_valid), 32'(e.uv));
                check("issue_opcode", 32'(issue_opcode), 32'(e.op));
                check("issue_payload", 32'(issue_payload), 32'(e.pl));
            end
        end
        if (illegal_op) ill_cnt++;
        if (w_req && w_exp.size() > 0) begin
            check("wrap_addr", 32'(w_addr), 32'(w_exp.pop_front()));
        end
    end

    task automatic expect_issue(input logic [2:0] uv, input logic [31:0] word);
        exp_t e;
        e.uv = uv;
        e.op = word[31:24];
        e.pl = word[23:0];
        sb.push_back(e);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) imem[i] = 32'h7E00_0000;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halted(input string name);
        int n = 0;
        while (!halted && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(halted), 32'h1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_valid(input string name, input logic [2:0] uv);
        int n = 0;
        while (unit_valid !== uv && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(unit_valid), 32'(uv));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_req"},     32'(instr_req), 32'h0);
        check({tag, "_addr"},    32'(instr_address), 32'h0);
        check({tag, "_uv"},      32'(unit_valid), 32'h0);
        check({tag, "_busy"},    32'(busy), 32'h0);
        check({tag, "_halted"},  32'(halted), 32'h0);
        check({tag, "_illegal"}, 32'(illegal_op), 32'h0);
        check({tag, "_opcode"},  32'(issue_opcode), 32'h0);
        check({tag, "_payload"}, 32'(issue_payload), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        w_start     = 1'b0;
        unit_ready  = 3'b000;
        w_ready     = 3'b111;
        instr_valid = 1'b0;
        instr_in    = '0;
        w_valid     = 1'b0;
        w_in        = '0;
        clear_mem();
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        // Stream: ADD, WRITE, HALT with all units ready.
        imem[0] = 32'h0300_0C41;
        imem[1] = 32'h0400_0123;
        imem[2] = 32'hFF00_0000;
        unit_ready = 3'b111;
        expect_issue(3'b010, 32'h0300_0C41);
        expect_issue(3'b001, 32'h0400_0123);
        hs_cyc.delete();
        req_log.delete();
        pulse_start();
        wait_halted("stream_halted");
        check("stream_busy", 32'(busy), 32'h0);
        check("stream_issues", 32'(hs_cyc.size()), 32'd2);
        if (hs_cyc.size() == 2) check("stream_gap", 32'(hs_cyc[1] - hs_cyc[0]), 32'd1);
        check("stream_nreq", 32'(req_log.size()), 32'd4);
        if (req_log.size() > 0) check("stream_last_addr", 32'(req_log[req_log.size()-1]), 32'd3);

        // Back-pressure: VXM not ready for 5 cycles, other units' ready high.
        clear_mem();
        imem[0] = 32'h0300_0055;
        imem[1] = 32'h0200_0077;
        imem[2] = 32'h0100_0011;
        imem[3] = 32'h0000_0000;
        imem[4] = 32'h0000_0000;
        imem[5] = 32'hFF00_0000;
        unit_ready = 3'b101;
        expect_issue(3'b010, 32'h0300_0055);
        expect_issue(3'b100, 32'h0200_0077);
        expect_issue(3'b001, 32'h0100_0011);
        req_log.delete();
        pulse_start();
        wait_valid("bp_first", 3'b010);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_uv", 32'(unit_valid), 32'h2);
            check("bp_hold_payload", 32'(issue_payload), 32'h55);
            @(negedge clk);
        end
        check("bp_full_req", 32'(instr_req), 32'h0);
        check("bp_nreq", 32'(req_log.size()), 32'd4);
        unit_ready = 3'b111;
        wait_halted("bp_halted");

        // NOP timing: NOP 3 and NOP 0 between ADDs.
        clear_mem();
        imem[0] = 32'h0300_0001;
        imem[1] = 32'h0000_0003;
        imem[2] = 32'h0300_0002;
        imem[3] = 32'h0000_0000;
        imem[4] = 32'h0300_0003;
        imem[5] = 32'hFF00_0000;
        expect_issue(3'b010, 32'h0300_0001);
        expect_issue(3'b010, 32'h0300_0002);
        expect_issue(3'b010, 32'h0300_0003);
        hs_cyc.delete();
        pulse_start();
        wait_halted("nop_halted");
        check("nop_issues", 32'(hs_cyc.size()), 32'd3);
        if (hs_cyc.size() == 3) begin
            check("nop3_gap", 32'(hs_cyc[1] - hs_cyc[0]), 32'd5);
            check("nop0_gap", 32'(hs_cyc[2] - hs_cyc[1]), 32'd2);
        end

        // Illegal opcode between READ and ADD.
        clear_mem();
        imem[0] = 32'h0100_0AAA;
        imem[1] = 32'h7E12_3456;
        imem[2] = 32'h0300_0BBB;
        imem[3] = 32'hFF00_0000;
        expect_issue(3'b001, 32'h0100_0AAA);
        expect_issue(3'b010, 32'h0300_0BBB);
        hs_cyc.delete();
        ill_cnt = 0;
        pulse_start();
        wait_halted("ill_halted");
        check("ill_pulses", 32'(ill_cnt), 32'd1);
        check("ill_issues", 32'(hs_cyc.size()), 32'd2);
        if (hs_cyc.size() == 2) check("ill_gap", 32'(hs_cyc[1] - hs_cyc[0]), 32'd2);

        // Reset in the middle of a stalled handshake.
        clear_mem();
        imem[0] = 32'h0300_0999;
        imem[1] = 32'hFF00_0000;
        unit_ready = 3'b101;
        pulse_start();
        wait_valid("rst_pending", 3'b010);
        rst = 1'b1;
        @(negedge clk);
        check_idle("midrst");
        rst = 1'b0;
        unit_ready = 3'b111;
        sb.delete();
        req_log.delete();
        expect_issue(3'b010, 32'h0300_0999);
        pulse_start();
        wait_halted("rerun_halted");
        check("rerun_nreq_nonzero", 32'(req_log.size() > 0), 32'h1);
        if (req_log.size() > 0) check("rerun_first_addr", 32'(req_log[0]), 32'h0);

        check("sb_drained", 32'(sb.size()), 32'h0);

        // Address wrap on the 3-bit instance: 9 NOPs, then HALT at address 1.
        for (int i = 0; i < 8; i++) w_exp.push_back(3'(i));
        w_exp.push_back(3'd0);
        w_exp.push_back(3'd1);
        @(negedge clk);
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        begin
            int n = 0;
            while (!w_halted && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        check("wrap_halted", 32'(w_halted), 32'h1);
        check("wrap_addrs_seen", 32'(w_exp.size()), 32'h0);
        check("wrap_busy", 32'(w_busy), 32'h0);
        check("wrap_no_issue", 32'(w_uv), 32'h0);
        check("wrap_no_illegal", 32'(w_ill), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/icu_issue_queue.md
Name: icu_issue_queue

Overview:
- Parametrised successor to the single-cycle ICU dispatcher.
- Fetches instructions from instruction memory into a FIFO and decodes them in order.
- Issues each instruction to one of NUM_UNITS functional-unit channels (MEM, VXM, SRF) over a valid/ready handshake, with back-pressure, NOP-N timed stalls and HALT.
- Sits between instruction memory and the MEM/VXM/SRF slice controllers.

Parameters:
- INSTR_WIDTH, 32: instruction word width; opcode is [31:24], payload is [23:0].
- INSTR_MEM_ADDR_WIDTH, 10: instruction address width.
- FIFO_DEPTH, 4: instruction buffer entries; power of two, minimum 2.
- NUM_UNITS, 3: issue channels; 0=MEM, 1=VXM, 2=SRF.
- NOP_CNT_WIDTH, 16: width of the NOP stall counter; NOP count is payload[15:0].

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse: begin fetching at address 0 from IDLE or HALTED.
- instr_req  out  1  fetch request for instr_address.
- instr_address  out  INSTR_MEM_ADDR_WIDTH  fetch address.
- instr_valid  in  1  asserted exactly 1 cycle after instr_req; data for that request.
- instr_in  in  INSTR_WIDTH  fetched word.
- unit_valid  out  NUM_UNITS  one-hot issue strobe.
- unit_ready  in  NUM_UNITS  per-unit accept.
- issue_opcode  out  8  opcode of the issuing instruction.
- issue_payload  out  24  payload of the issuing instruction.
- busy  out  1  state is not IDLE or HALTED.
- halted  out  1  state is HALTED.
- illegal_op  out  1  1-cycle pulse when an undefined opcode is dropped.

Behaviour:
- Reset:
  - State goes to IDLE; FIFO is emptied; the outstanding-fetch flag is cleared.
  - instr_address=0; instr_req, unit_valid, busy, halted and illegal_op are 0.
  - issue_opcode and issue_payload are 0.
- States: IDLE, RUN, NOP_WAIT, HALTED.
  - IDLE→RUN and HALTED→RUN on start; this sets instr_address=0 and flushes the FIFO.
  - start is ignored in RUN and NOP_WAIT.
- Fetch (RUN and NOP_WAIT only):
  - instr_req=1 when fifo_count + outstanding < FIFO_DEPTH.
  - instr_address increments by 1 in the cycle after each request and wraps modulo 2^INSTR_MEM_ADDR_WIDTH.
  - An instr_valid word is pushed to the FIFO. Responses are never dropped, except in HALTED, where they are discarded.
- Decode/issue, head of FIFO, RUN only, in order, at most 1 instruction per cycle:
  - 0x01 READ and 0x04 WRITE go to unit 0.
  - 0x03 ADD goes to unit 1.
  - 0x02 MOVE goes to unit 2.
  - Issue is registered: unit_valid, issue_opcode and issue_payload are driven from the FIFO head in the cycle after it becomes the head.
  - unit_valid holds, with stable opcode and payload, until that unit's ready is sampled high. Pop happens on valid&&ready.
  - Back-to-back issues are allowed: a new head may be presented in the cycle after the handshake.
  - ready on a non-selected unit is ignored.
- 0x00 NOP N:
  - Popped in 1 cycle; no unit_valid.
  - If N>0, go to NOP_WAIT for exactly N cycles, then return to RUN. N=0 costs only the pop cycle.
  - Fetching continues during NOP_WAIT.
- 0xFF HALT:
  - Popped; the FIFO is flushed and fetching stops.
  - Go to HALTED next cycle. An in-flight instr_valid response is discarded.
- Other opcodes: popped, dropped, illegal_op pulses for 1 cycle, no issue.
- FIFO full: instr_req is 0; fetch resumes the cycle after a pop.
- FIFO empty in RUN: no issue; remain in RUN.
- rst mid-handshake or during NOP_WAIT: immediate return to reset values. The pending issue is abandoned.

Decomposition:
- Package icu_pkg contains:
  - opcode localparams: OP_NOP, OP_MOVE, OP_READ, OP_ADD, OP_WRITE, OP_HALT;
  - unit index constants: UNIT_MEM, UNIT_VXM, UNIT_SRF;
  - state enum icu_state_t;
  - function opcode_to_unit, which returns the unit index plus a legal flag.
- Sub-module icu_instr_fifo: synchronous FIFO parametrised by width and depth, with push, pop, flush, count, full and empty.

Test Plan:
- Stream: start; memory holds ADD(0x03000C41), WRITE(0x04...), HALT, with all ready=1. Required: unit_valid=3'b010 then 3'b001, consecutive cycles; payloads exact; halted=1 after HALT; no request issued beyond address 3.
- Back-pressure: unit_ready[1]=0 for 5 cycles while ADD is at the head. Required: unit_valid[1] and its payload stable for those 5 cycles, then 1 handshake; FIFO never exceeds 4; instr_req drops while the FIFO is full.
- NOP timing: NOP 3 between two ADDs. Required: exactly 3 NOP_WAIT cycles plus the pop cycle between the two issues; NOP 0 adds only the pop cycle.
- Illegal opcode 0x7E between READ and ADD. Required: illegal_op pulses once; READ and ADD both issue; no unit_valid for 0x7E.
- Reset mid-operation: assert rst while unit_valid=1 and ready=0. Required: next cycle all outputs are 0, state IDLE, instr_address=0; after start, fetch resumes from 0.
- Address wrap with INSTR_MEM_ADDR_WIDTH=3: 9 NOPs then HALT. Required: instr_address goes 7→0 and the HALT fetched at address 1 (after the wrap) is honoured.
